uart_rx_ctrl: RTL

//  Receive-side controller behind the 16x-oversampled UART receiver (uartrx).
//  - Watches the receiver's byte-valid and error flags and classifies each completed frame.
//  - Queues good bytes in a small show-ahead FIFO with a valid/ready output.
//  - Drops bad bytes and keeps saturating error statistics for the host/CPU side.

---
 rtl/uart_rx_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ctrl
// Description : Frame classifier, show-ahead byte FIFO and error statistics
//               behind a 16x-oversampled UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_en,
  input  logic             rx_dataerror,
  input  logic             rx_frameerror,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW:0]      fifo_count,
  output logic             overflow,
  output logic [CNT_W-1:0] parity_errs,
  output logic [CNT_W-1:0] frame_errs,
  input  logic             clr_stat,
  output logic             rx_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_EVAL = 2'd2
  } state_t;

  localparam logic [AW:0]      c_depth = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] c_ones  = '1;

  state_t           r_state;
  logic             r_rx_en_d;
  logic             r_seen_low;
  logic [7:0]       r_cap_data;
  logic             r_cap_perr;
  logic             r_cap_ferr;
  logic [7:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overflow;
  logic [CNT_W-1:0] r_perr_cnt;
  logic [CNT_W-1:0] r_ferr_cnt;

  logic w_fall;
  logic w_eval;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_fall = r_rx_en_d & ~rx_en;
  assign w_eval = (r_state == S_EVAL);
  assign w_full = (r_count == c_depth);
  assign w_push = w_eval & ~r_cap_ferr & ~r_cap_perr & ~w_full;
  assign w_pop  = (r_count != '0) & out_ready;

  // A frame already in flight when reset releases is not tracked: rx_en must
  // be seen low once before a new frame can be accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_rx_en_d  <= 1'b0;
      r_seen_low <= 1'b0;
      r_cap_data <= '0;
      r_cap_perr <= 1'b0;
      r_cap_ferr <= 1'b0;
    end else begin
      r_rx_en_d <= rx_en;
      if (!rx_en) r_seen_low <= 1'b1;
      case (r_state)
        S_IDLE: if (rx_en && r_seen_low) r_state <= S_RECV;
        S_RECV: begin
          if (w_fall) begin
            r_state    <= S_EVAL;
            r_cap_data <= rx_data;
            r_cap_perr <= rx_dataerror;
            r_cap_ferr <= rx_frameerror;
          end
        end
        S_EVAL:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_cap_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Fullness is judged on the pre-pop count, so a push against a full FIFO
  // is dropped even when a pop lands in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
      r_perr_cnt <= '0;
      r_ferr_cnt <= '0;
    end else if (clr_stat) begin
      r_overflow <= 1'b0;
      r_perr_cnt <= '0;
      r_ferr_cnt <= '0;
    end else if (w_eval) begin
      if (r_cap_ferr) begin
        if (r_ferr_cnt != c_ones) r_ferr_cnt <= r_ferr_cnt + CNT_W'(1);
      end else if (r_cap_perr) begin
        if (r_perr_cnt != c_ones) r_perr_cnt <= r_perr_cnt + CNT_W'(1);
      end else if (w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign out_data    = r_mem[r_rd_ptr];
  assign out_valid   = (r_count != '0);
  assign fifo_count  = r_count;
  assign overflow    = r_overflow;
  assign parity_errs = r_perr_cnt;
  assign frame_errs  = r_ferr_cnt;
  assign rx_busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire
